// File: rtl/jtcop_pkg.sv
// rtl/jtcop_pkg.sv - shared constants and Sly Spy preset table for the bank mapper
package jtcop_pkg;

    localparam int CODE_W   = 3;

    localparam int CH_BMODE = 0;
    localparam int CH_BSFT  = 1;
    localparam int CH_BMAP  = 2;
    localparam int CH_FMODE = 3;
    localparam int CH_FSFT  = 4;
    localparam int CH_FMAP  = 5;

    // Returns the table code (channel+1, or 0 for no select) for {page, region}
    function automatic int preset_code(int page, int region);
        int ch;
        ch = -1;
        case (page)
            0: case (region)
                0: ch = CH_BMODE;
                1: ch = CH_BSFT;
                3: ch = CH_BMAP;
                4: ch = CH_FMODE;
                6: ch = CH_FSFT;
                7: ch = CH_FMAP;
                default: ch = -1;
            endcase
            1: case (region)
                4: ch = CH_FMAP;
                6: ch = CH_BMAP;
                default: ch = -1;
            endcase
            2: case (region)
                0: ch = CH_BMAP;
                1: ch = CH_FMAP;
                7: ch = CH_FMAP;
                default: ch = -1;
            endcase
            3: case (region)
                0: ch = CH_FMAP;
                4: ch = CH_BMAP;
                default: ch = -1;
            endcase
            default: ch = -1;
        endcase
        return ch + 1;
    endfunction

endpackage

// File: rtl/jtcop_bankmap_if.sv
// rtl/jtcop_bankmap_if.sv - CPU window, table programming and select outputs of the bank mapper
interface jtcop_bankmap_if #(
    parameter int SELW = 2,
    parameter int RGW  = 3,
    parameter int NCH  = 6,
    parameter int CODW = 3
);
    logic                 win_cs;
    logic                 ASn;
    logic                 RnW;
    logic [RGW-1:0]       rgn;
    logic                 prog_en;
    logic                 prog_we;
    logic [SELW+RGW-1:0]  prog_addr;
    logic [CODW-1:0]      prog_data;
    logic [NCH-1:0]       ch_cs;
    logic                 any_cs;
    logic [SELW-1:0]      mapsel;
    logic [SELW-1:0]      cnt;

    modport master (
        output win_cs, ASn, RnW, rgn, prog_en, prog_we, prog_addr, prog_data,
        input  ch_cs, any_cs, mapsel, cnt
    );

    modport slave (
        input  win_cs, ASn, RnW, rgn, prog_en, prog_we, prog_addr, prog_data,
        output ch_cs, any_cs, mapsel, cnt
    );
endinterface

// File: rtl/jtcop_bankmap_cnt.sv
// rtl/jtcop_bankmap_cnt.sv - protection counter with edge detect and per-bus-cycle page latch
module jtcop_bankmap_cnt #(
    parameter int SELW = 2,
    parameter int WRAP = 1
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            ASn,
    input  logic            up,
    input  logic            clr,
    output logic [SELW-1:0] cnt,
    output logic [SELW-1:0] mapsel
);
    localparam logic [SELW-1:0] CNT_MAX = '1;

    logic upl, clrl;
    logic up_re, clr_re;

    assign up_re  = up  & ~upl;
    assign clr_re = clr & ~clrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upl    <= 1'b0;
            clrl   <= 1'b0;
            cnt    <= '0;
            mapsel <= '0;
        end else begin
            upl  <= up;
            clrl <= clr;
            if (clr_re) begin
                cnt <= '0;
            end else if (up_re) begin
                if (WRAP != 0 || cnt != CNT_MAX)
                    cnt <= cnt + SELW'(1);
            end
            // Page only moves between bus cycles so a count never retargets its own access
            if (ASn)
                mapsel <= cnt;
        end
    end
endmodule

// File: rtl/jtcop_bankmap.sv
// rtl/jtcop_bankmap.sv - table-driven chip-select remapper for the scrambled tilemap window
module jtcop_bankmap
    import jtcop_pkg::*;
#(
    parameter int SELW    = 2,
    parameter int RGW     = 3,
    parameter int NCH     = 6,
    parameter int CODW    = CODE_W,
    parameter int UP_RGN  = 2,
    parameter int CLR_RGN = 5,
    parameter int WRAP    = 1,
    parameter int PRESET  = 1
) (
    input  logic            rst,
    input  logic            clk,
    jtcop_bankmap_if.slave  bus
);
    localparam int MAPS = 1 << SELW;
    localparam int NENT = MAPS << RGW;
    localparam int RMSK = (1 << RGW) - 1;

    logic [CODW-1:0] tbl [NENT];
    logic [CODW-1:0] entry;
    logic            up, clr, act;
    logic [NCH-1:0]  ch;
    logic [SELW-1:0] cnt_q, mapsel_q;

    assign up  = ~bus.ASn & bus.win_cs &  bus.RnW & (bus.rgn == RGW'(UP_RGN));
    assign clr = ~bus.ASn & bus.win_cs & ~bus.RnW & (bus.rgn == RGW'(CLR_RGN));

    jtcop_bankmap_cnt #(
        .SELW (SELW),
        .WRAP (WRAP)
    ) u_cnt (
        .rst    (rst),
        .clk    (clk),
        .ASn    (bus.ASn),
        .up     (up),
        .clr    (clr),
        .cnt    (cnt_q),
        .mapsel (mapsel_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++)
                tbl[i] <= (PRESET != 0) ? CODW'(preset_code(i >> RGW, i & RMSK)) : '0;
        end else if (bus.prog_en && bus.prog_we) begin
            tbl[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign entry = tbl[{mapsel_q, bus.rgn}];
    // rst gates the outputs directly so they drop mid-cycle, not at the next edge
    assign act   = ~rst & ~bus.ASn & bus.win_cs & ~bus.prog_en;

    always_comb begin
        ch = '0;
        for (int k = 0; k < NCH; k++)
            ch[k] = act && (entry == CODW'(k + 1));
    end

    assign bus.ch_cs  = ch;
    assign bus.any_cs = |ch;
    assign bus.cnt    = cnt_q;
    assign bus.mapsel = mapsel_q;
endmodule

// File: tb/tb_jtcop_bankmap.sv
// tb/tb_jtcop_bankmap.sv - directed self-checking bench for jtcop_bankmap
module tb_jtcop_bankmap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jtcop_bankmap_if #(.SELW(2), .RGW(3), .NCH(6), .CODW(3)) bw ();
    jtcop_bankmap_if #(.SELW(2), .RGW(3), .NCH(6), .CODW(3)) bs ();

    assign bs.win_cs    = bw.win_cs;
    assign bs.ASn       = bw.ASn;
    assign bs.RnW       = bw.RnW;
    assign bs.rgn       = bw.rgn;
    assign bs.prog_en   = bw.prog_en;
    assign bs.prog_we   = bw.prog_we;
    assign bs.prog_addr = bw.prog_addr;
    assign bs.prog_data = bw.prog_data;

    jtcop_bankmap #(.WRAP(1), .PRESET(1)) dut_w (.rst(rst), .clk(clk), .bus(bw));
    jtcop_bankmap #(.WRAP(0), .PRESET(1)) dut_s (.rst(rst), .clk(clk), .bus(bs));

    logic       f_asn = 1'b1, f_up = 1'b0, f_clr = 1'b0;
    logic [1:0] f_cnt, f_map;

    jtcop_bankmap_cnt #(.SELW(2), .WRAP(1)) u_force (
        .rst(rst), .clk(clk), .ASn(f_asn), .up(f_up), .clr(f_clr),
        .cnt(f_cnt), .mapsel(f_map)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_start(input logic rnw, input logic [2:0] r);
        bw.ASn    = 1'b0;
        bw.win_cs = 1'b1;
        bw.RnW    = rnw;
        bw.rgn    = r;
        #1;
    endtask

    task automatic bus_end();
        bw.ASn    = 1'b1;
        bw.win_cs = 1'b0;
        tick();
    endtask

    int exp_w [4] = '{1, 2, 3, 0};
    int exp_s [4] = '{1, 2, 3, 3};

    initial begin
        bw.ASn = 1'b1; bw.win_cs = 1'b0; bw.RnW = 1'b1; bw.rgn = '0;
        bw.prog_en = 1'b0; bw.prog_we = 1'b0; bw.prog_addr = '0; bw.prog_data = '0;

        // Reset held with an access in flight: outputs must stay quiet
        tick();
        bus_start(1'b1, 3'd3);
        check("rst_ch_cs", bw.ch_cs, 6'b000000);
        check("rst_any_cs", bw.any_cs, 1'b0);
        check("rst_cnt", bw.cnt, 2'd0);
        check("rst_mapsel", bw.mapsel, 2'd0);
        bw.ASn = 1'b1; bw.win_cs = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        bus_start(1'b1, 3'd3);
        check("p0_r3_bmap", bw.ch_cs, 6'b000100);
        check("p0_r3_any", bw.any_cs, 1'b1);
        check("p0_mapsel", bw.mapsel, 2'd0);
        bus_end();

        // Two up-reads, each a separate bus cycle
        bus_start(1'b1, 3'd2);
        tick();
        check("up1_cnt", bw.cnt, 2'd1);
        check("up1_mapsel_hold", bw.mapsel, 2'd0);
        bus_end();
        check("up1_mapsel", bw.mapsel, 2'd1);
        bus_start(1'b1, 3'd2);
        tick();
        bus_end();
        check("up2_cnt", bw.cnt, 2'd2);
        check("up2_mapsel", bw.mapsel, 2'd2);
        bus_start(1'b1, 3'd7);
        check("p2_r7_fmap", bw.ch_cs, 6'b100000);
        bw.rgn = 3'd3;
        #1;
        check("p2_r3_none", bw.ch_cs, 6'b000000);
        check("p2_r3_any", bw.any_cs, 1'b0);
        bus_end();

        // Clear, then four up-reads on both wrap and saturate instances
        bus_start(1'b0, 3'd5);
        tick();
        check("clr_cnt", bw.cnt, 2'd0);
        bus_end();
        for (int i = 0; i < 4; i++) begin
            bus_start(1'b1, 3'd2);
            tick();
            check($sformatf("wrap_cnt%0d", i), bw.cnt, exp_w[i]);
            check($sformatf("sat_cnt%0d", i), bs.cnt, exp_s[i]);
            bus_end();
        end
        check("wrap_mapsel", bw.mapsel, 2'd0);

        // One long strobe counts once and keeps the page until ASn rises
        bus_start(1'b1, 3'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("long_cnt%0d", i), bw.cnt, 2'd1);
            check($sformatf("long_map%0d", i), bw.mapsel, 2'd0);
        end
        bus_end();
        check("long_mapsel", bw.mapsel, 2'd1);

        for (int i = 0; i < 2; i++) begin
            bus_start(1'b1, 3'd2);
            tick();
            bus_end();
        end
        bus_start(1'b0, 3'd5);
        check("clr_pre_cnt", bw.cnt, 2'd3);
        tick();
        check("clr3_cnt", bw.cnt, 2'd0);
        bus_end();

        // Simultaneous up and clear edges on a standalone counter
        f_up = 1'b1; tick();
        f_up = 1'b0; tick();
        f_up = 1'b1; tick();
        f_up = 1'b0; tick();
        check("force_pre_cnt", f_cnt, 2'd2);
        f_up = 1'b1; f_clr = 1'b1; tick();
        check("force_clr_wins", f_cnt, 2'd0);
        f_up = 1'b0; f_clr = 1'b0; tick();
        check("force_mapsel", f_map, 2'd0);

        // Enter page 1, program {1,2}=4 and observe the gating by prog_en
        bus_start(1'b1, 3'd2);
        tick();
        bus_end();
        check("pg1_mapsel", bw.mapsel, 2'd1);
        bw.prog_en = 1'b1; bw.prog_we = 1'b1;
        bw.prog_addr = 5'b01_010; bw.prog_data = 3'd4;
        tick();
        bw.prog_we = 1'b0;
        bus_start(1'b1, 3'd2);
        check("prog_gate", bw.ch_cs, 6'b000000);
        tick();
        bw.prog_en = 1'b0;
        #1;
        check("prog_fmode", bw.ch_cs, 6'b001000);
        check("prog_cnt", bw.cnt, 2'd2);
        check("prog_mapsel", bw.mapsel, 2'd1);
        bw.prog_we = 1'b1; bw.prog_data = 3'd1;
        tick();
        bw.prog_we = 1'b0;
        #1;
        check("prog_we_ignored", bw.ch_cs, 6'b001000);
        bus_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtcop_bankmap.md
Name: jtcop_bankmap

Overview:
- Parametrised, table-driven chip-select remapper for the protection-scrambled tilemap window (Sly Spy-style address scrambling), generalised from a fixed 4-state scheme.
- Sits between the main CPU address decoder and the BAC06 tilemap chips.
- A protection counter, stepped by bus reads and cleared by bus writes to configurable regions, selects one of 2^SELW mapping pages.
- Each page maps an address region to one of NCH chip selects; the table is run-time loadable and has an optional Sly Spy preset.

Parameters:
- SELW, 2: counter/page width; MAPS = 2^SELW pages.
- RGW, 3: region index width; 2^RGW regions per page.
- NCH, 6: number of chip-select outputs.
- CODW, 3: table entry width. Code 0 = no select; code k = ch_cs[k-1]. Requires NCH < 2^CODW.
- UP_RGN, 2: region whose read steps the counter.
- CLR_RGN, 5: region whose write clears the counter.
- WRAP, 1: 1 = counter wraps at MAPS-1; 0 = counter saturates at MAPS-1.
- PRESET, 1: 1 = reset loads the Sly Spy table; 0 = reset loads all zeros.

Ports:
- rst  in  1  asynchronous, active-high reset.
- clk  in  1  system clock.
- win_cs  in  1  scrambled window hit, already qualified by the upstream decoder.
- ASn  in  1  CPU address strobe, active low.
- RnW  in  1  CPU read/not-write.
- rgn  in  RGW  region index (CPU A[15:13] at default).
- prog_en  in  1  table programming active; forces ch_cs to 0.
- prog_we  in  1  table write strobe.
- prog_addr  in  SELW+RGW  {page, region}.
- prog_data  in  CODW  entry code.
- ch_cs  out  NCH  one-hot (or zero) chip selects.
- any_cs  out  1  OR of ch_cs.
- mapsel  out  SELW  page currently applied.
- cnt  out  SELW  pending counter value.

Behaviour:
- Reset (asynchronous):
  - cnt = 0, mapsel = 0, edge-detect registers = 0.
  - Table = preset (PRESET=1) or zeros (PRESET=0).
  - ch_cs = 0 and any_cs = 0 while rst is high.
- Events, evaluated combinationally each cycle:
  - up = !ASn & win_cs & RnW & rgn==UP_RGN
  - clr = !ASn & win_cs & !RnW & rgn==CLR_RGN
- Edge detection: upl and clrl are registered copies of up and clr. An action fires only on the cycle where the event is high and its registered copy is low, so one count per bus cycle regardless of strobe length.
- Counter update:
  - clr rising: cnt <= 0.
  - up rising, WRAP=1: cnt <= cnt+1, modulo MAPS.
  - up rising, WRAP=0: cnt <= min(cnt+1, MAPS-1).
  - Both rising in the same cycle: clear wins.
- Page latch:
  - On every cycle with ASn high: mapsel <= cnt.
  - While ASn is low, mapsel holds. A counter change therefore never affects the bus cycle that caused it; it applies from the next bus cycle.
- Select output:
  - ch_cs is combinational with zero latency: e = table[{mapsel, rgn}].
  - ch_cs[e-1] = !ASn & win_cs & !prog_en & e!=0 & e<=NCH.
  - Codes above NCH produce no select.
- Counting regions:
  - UP_RGN and CLR_RGN entries may themselves be nonzero; their selects still assert. The preset leaves both zero.
- Table:
  - Storage: MAPS*2^RGW entries of CODW bits in a register array.
  - Write: synchronous on prog_we, takes effect the next cycle. prog_we is ignored unless prog_en is high.
  - Read: asynchronous.
  - A table write to the currently selected entry during a bus access changes ch_cs the following cycle; this is allowed.
- Preset table, listed as page: region→channel.
  - Channels: 0=bmode, 1=bsft, 2=bmap, 3=fmode, 4=fsft, 5=fmap.
  - P0: r0→0, r1→1, r3→2, r4→3, r6→4, r7→5.
  - P1: r4→5, r6→2.
  - P2: r0→2, r1→5, r7→5.
  - P3: r0→5, r4→2.
  - All other entries: 0.
- Reset during an active bus cycle: outputs clear immediately. After release, the first cycle with ASn high loads mapsel = 0.

Decomposition:
- Shared package jtcop_pkg holds:
  - channel index constants: CH_BMODE..CH_FMAP.
  - code width constant.
  - preset table as a localparam function that returns the entry for {page, region}.
- One sub-module, jtcop_bankmap_cnt, contains the edge detectors, the counter with WRAP/saturate logic and clear priority, and the ASn page latch.
- The top module holds the table and the select decode.

Test Plan:
- Reset, PRESET=1, then read at rgn=3 → ch_cs=6'b000100 (bmap); mapsel=0.
- Two reads to rgn=2, each with ASn high between them, then access rgn=7 → cnt=2, mapsel=2, ch_cs=6'b100000 (fmap). An access to rgn=3 in page 2 → ch_cs=0.
- Four up-reads with WRAP=1 → cnt goes 1,2,3,0. Repeat with WRAP=0 → cnt stays at 3 after the third read.
- Single ASn-low window lasting 10 cycles at rgn=2 → cnt increments exactly once. mapsel stays unchanged until ASn rises, then equals 1.
- Write to rgn=5 with cnt=3 → cnt=0 the next cycle. Force up and clr rising in the same cycle (directed override) → cnt=0.
- prog_en=1, write entry {page 1, region 2} = code 4 → the following access in page 1 at rgn=2 during prog_en gives ch_cs=0. After prog_en drops, the same access gives ch_cs=6'b001000, and cnt also increments.
